// File: rtl/led_mem_ctrl.sv
// LED memory controller: round-robin write arbiter on port A (bulk zero-fill compiled in
// with LEDMEM_CLEAR_EN), once-per-frame scan of all cells on port B into a snapshot.
module led_mem_ctrl #(
  parameter int NCELLS = 36,
  parameter int AW     = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [AW-1:0]     addr0,
  input  logic [AW-1:0]     addr1,
  input  logic              data0,
  input  logic              data1,
  output logic              gnt0,
  output logic              gnt1,
  input  logic              clear_req,
  input  logic              frame_start,
  output logic              memA_we,
  output logic [AW-1:0]     memA_addr,
  output logic              memA_din,
  output logic [AW-1:0]     memB_addr,
  input  logic              memB_dout,
  output logic [NCELLS-1:0] frame,
  output logic              frame_valid,
  output logic              busy
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NCELLS - 1);

  typedef enum logic {ARB, CLEAR} a_state_t;
  typedef enum logic {SIDLE, SCAN} s_state_t;

  a_state_t          r_a_state, w_a_state;
  logic              r_ptr, w_ptr;
  logic              r_gnt0, w_gnt0, r_gnt1, w_gnt1;
  logic              r_we, w_we, r_din, w_din, r_busy, w_busy;
  logic [AW-1:0]     r_addr, w_addr;
  logic              w_arb, w_elig0, w_elig1, w_pick1;

  s_state_t          r_s_state, w_s_state;
  logic [AW-1:0]     r_baddr, w_baddr;
  logic              r_last, w_last, r_rdv, w_rdv, r_fv, w_fv;
  logic [NCELLS-1:0] r_shadow, w_shadow, r_frame, w_frame;

`ifndef LEDMEM_CLEAR_EN
  logic w_unused_clear;
  assign w_unused_clear = clear_req;
`endif

  // A requester whose grant is showing this cycle sits out one round.
  assign w_elig0 = req0 & ~r_gnt0;
  assign w_elig1 = req1 & ~r_gnt1;
  assign w_pick1 = w_elig1 & (~w_elig0 | r_ptr);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_a_state = r_a_state;
    w_ptr     = r_ptr;
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    w_we      = 1'b0;
    w_busy    = 1'b0;
    w_addr    = r_addr;
    w_din     = r_din;
    w_arb     = 1'b0;
    case (r_a_state)
      ARB: begin
`ifdef LEDMEM_CLEAR_EN
        if (clear_req) begin
          w_a_state = CLEAR;
          w_we      = 1'b1;
          w_busy    = 1'b1;
          w_addr    = '0;
          w_din     = 1'b0;
        end else begin
          w_arb = 1'b1;
        end
`else
        w_arb = 1'b1;
`endif
      end
`ifdef LEDMEM_CLEAR_EN
      CLEAR: begin
        if (r_addr == LAST_ADDR) begin
          w_a_state = ARB;
          w_arb     = 1'b1;
        end else begin
          w_we   = 1'b1;
          w_busy = 1'b1;
          w_addr = r_addr + AW'(1);
          w_din  = 1'b0;
        end
      end
`endif
      default: w_a_state = ARB;
    endcase

    // Out-of-range writes still get their grant but never reach the array.
    if (w_arb && (w_elig0 || w_elig1)) begin
      if (w_pick1) begin
        w_gnt1 = 1'b1;
        w_addr = addr1;
        w_din  = data1;
        w_ptr  = 1'b0;
      end else begin
        w_gnt0 = 1'b1;
        w_addr = addr0;
        w_din  = data0;
        w_ptr  = 1'b1;
      end
      w_we = (w_addr <= LAST_ADDR);
    end
  end

  always_comb begin
    w_s_state = r_s_state;
    w_baddr   = r_baddr;
    w_last    = r_last;
    w_rdv     = 1'b0;
    w_shadow  = r_shadow;
    w_frame   = r_frame;
    w_fv      = 1'b0;
    case (r_s_state)
      SIDLE: begin
        if (frame_start) begin
          w_s_state = SCAN;
          w_baddr   = '0;
          w_last    = 1'b0;
        end
      end
      SCAN: begin
        // Read data lags its address by one cycle; cell 0 ends up in bit 0.
        if (r_rdv) w_shadow = {memB_dout, r_shadow[NCELLS-1:1]};
        if (r_last) begin
          w_frame   = w_shadow;
          w_fv      = 1'b1;
          w_s_state = SIDLE;
          w_baddr   = '0;
        end else begin
          w_rdv = 1'b1;
          if (r_baddr == LAST_ADDR) w_last = 1'b1;
          else                      w_baddr = r_baddr + AW'(1);
        end
      end
      default: w_s_state = SIDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_a_state <= ARB;
      r_ptr     <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_din     <= 1'b0;
      r_busy    <= 1'b0;
      r_s_state <= SIDLE;
      r_baddr   <= '0;
      r_last    <= 1'b0;
      r_rdv     <= 1'b0;
      r_frame   <= '0;
      r_fv      <= 1'b0;
    end else begin
      r_a_state <= w_a_state;
      r_ptr     <= w_ptr;
      r_gnt0    <= w_gnt0;
      r_gnt1    <= w_gnt1;
      r_we      <= w_we;
      r_addr    <= w_addr;
      r_din     <= w_din;
      r_busy    <= w_busy;
      r_s_state <= w_s_state;
      r_baddr   <= w_baddr;
      r_last    <= w_last;
      r_rdv     <= w_rdv;
      r_frame   <= w_frame;
      r_fv      <= w_fv;
    end
  end

  // NOTE: the shadow is fully rewritten before it is ever copied out, so it carries no reset.
  always_ff @(posedge clock) begin
    r_shadow <= w_shadow;
  end

  assign gnt0        = r_gnt0;
  assign gnt1        = r_gnt1;
  assign memA_we     = r_we;
  assign memA_addr   = r_addr;
  assign memA_din    = r_din;
  assign busy        = r_busy;
  assign memB_addr   = r_baddr;
  assign frame       = r_frame;
  assign frame_valid = r_fv;

endmodule
